// File: rtl/msi_fab_ring_stop.sv
// Fabric ring stop: drops flits addressed here, forwards other traffic, and fills free slots from a small add FIFO.
// Ring hop is one registered cycle. There is no back-pressure on the ring. Adds made while the FIFO is full are lost and flagged.
module msi_fab_ring_stop #(
  parameter logic [5:0] STOP_ID   = 6'd1,
  parameter int         ADD_DEPTH = 4,
  parameter int         ADD_AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] ring_in,
  output logic [79:0] ring_out,
  input  logic [79:0] add_bus80,
  output logic [79:0] drop_bus80,
  output logic        add_full,
  output logic        add_overflow,
  output logic        orphan_err
);

  localparam logic [5:0]      BCAST_ID = 6'h3F;
  localparam logic [ADD_AW:0] DEPTH_C  = (ADD_AW+1)'(ADD_DEPTH);

  logic              v;
  logic [5:0]        dest;
  logic [5:0]        src;
  logic              is_drop, is_bown, is_bcast, is_orphan;
  logic              slot_free, fwd;
  logic              pop, push, fifo_empty, fifo_at_cap;
  logic [ADD_AW:0]   count, count_nxt;
  logic [ADD_AW-1:0] rd_ptr, wr_ptr;
  logic [79:0]       mem [ADD_DEPTH];
  logic [79:0]       ins_flit;

  assign v    = ring_in[79];
  assign dest = ring_in[78:73];
  assign src  = ring_in[72:67];

  assign is_drop   = v && (dest == STOP_ID);
  assign is_bown   = v && (dest == BCAST_ID) && (src == STOP_ID);
  assign is_bcast  = v && (dest == BCAST_ID) && (src != STOP_ID);
  assign is_orphan = v && (dest != STOP_ID) && (dest != BCAST_ID) && (src == STOP_ID);

  // Only PASS and foreign broadcasts keep the slot; everything else may be refilled.
  assign slot_free = !v || is_drop || is_bown || is_orphan;
  assign fwd       = v && !slot_free;

  assign fifo_empty  = (count == '0);
  assign fifo_at_cap = (count == DEPTH_C);
  assign pop         = slot_free && !fifo_empty;
  assign push        = add_bus80[79] && (!fifo_at_cap || pop);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Inserted flits always carry this stop as source, whatever the cluster put there.
  assign ins_flit = {mem[rd_ptr][79:73], STOP_ID, mem[rd_ptr][66:0]};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= add_bus80;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_out     <= 80'h0;
      drop_bus80   <= 80'h0;
      add_full     <= 1'b0;
      add_overflow <= 1'b0;
      orphan_err   <= 1'b0;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
    end else begin
      if (fwd)      ring_out <= ring_in;
      else if (pop) ring_out <= ins_flit;
      else          ring_out <= 80'h0;

      drop_bus80 <= (is_drop || is_bcast) ? ring_in : 80'h0;
      orphan_err <= is_orphan;

      if (add_bus80[79] && fifo_at_cap && !pop) add_overflow <= 1'b1;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      add_full <= (count_nxt == DEPTH_C);
    end
  end

endmodule

// File: tb/tb_msi_fab_ring_stop.sv
// Bench for msi_fab_ring_stop: directed scenarios then random traffic against a queue-based model of the stop.
module tb_msi_fab_ring_stop;

  localparam logic [5:0] ID    = 6'd1;
  localparam int         DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [79:0] ring_in = '0;
  logic [79:0] add_bus80 = '0;
  logic [79:0] ring_out, drop_bus80;
  logic        add_full, add_overflow, orphan_err;

  int checks = 0;
  int failures = 0;

  logic [79:0] q[$];
  logic        m_ovf = 1'b0;

  msi_fab_ring_stop #(.STOP_ID(ID), .ADD_DEPTH(DEPTH), .ADD_AW(2)) dut (
    .clk(clk), .rst(rst), .ring_in(ring_in), .ring_out(ring_out),
    .add_bus80(add_bus80), .drop_bus80(drop_bus80), .add_full(add_full),
    .add_overflow(add_overflow), .orphan_err(orphan_err)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] mk(input logic vb, input logic [5:0] d, input logic [5:0] s,
                                     input logic [2:0] t, input logic [63:0] p);
    return {vb, d, s, t, p};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ring_out"}, ring_out, 80'h0);
    chk({tag, "_drop"}, drop_bus80, 80'h0);
    chk({tag, "_full"}, {79'h0, add_full}, 80'h0);
    chk({tag, "_ovf"}, {79'h0, add_overflow}, 80'h0);
    chk({tag, "_orphan"}, {79'h0, orphan_err}, 80'h0);
  endtask

  // One ring cycle: apply inputs, predict from the flit rules, clock, compare.
  task automatic step(input logic [79:0] rin, input logic [79:0] add);
    logic [79:0] exp_ring, exp_drop, f;
    logic        exp_orph, free, popped;
    int          had;
    ring_in = rin;
    add_bus80 = add;
    exp_ring = '0; exp_drop = '0; exp_orph = 1'b0; free = 1'b1; popped = 1'b0;
    if (rin[79]) begin
      if (rin[78:73] == ID) exp_drop = rin;
      else if (rin[78:73] == 6'h3F) begin
        if (rin[72:67] != ID) begin exp_drop = rin; exp_ring = rin; free = 1'b0; end
      end
      else if (rin[72:67] == ID) exp_orph = 1'b1;
      else begin exp_ring = rin; free = 1'b0; end
    end
    had = q.size();
    if (free && had > 0) begin
      f = q.pop_front();
      f[72:67] = ID;
      exp_ring = f;
      popped = 1'b1;
    end
    if (add[79]) begin
      if (had < DEPTH || popped) q.push_back(add);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("ring_out", ring_out, exp_ring);
    chk("drop_bus80", drop_bus80, exp_drop);
    chk("orphan_err", {79'h0, orphan_err}, {79'h0, exp_orph});
    chk("add_full", {79'h0, add_full}, {79'h0, (q.size() == DEPTH)});
    chk("add_overflow", {79'h0, add_overflow}, {79'h0, m_ovf});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ring_in = '0;
    add_bus80 = '0;
    q.delete();
    m_ovf = 1'b0;
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [79:0] rnd_ring();
    logic [5:0] d, s;
    int sel;
    sel = $urandom_range(0, 3);
    d = (sel == 0) ? ID : (sel == 1) ? 6'h3F : 6'($urandom);
    s = ($urandom_range(0, 2) == 0) ? ID : 6'($urandom);
    return mk($urandom_range(0, 3) != 0, d, s, 3'($urandom), {$urandom, $urandom});
  endfunction

  localparam logic [79:0] IDLE = 80'h0;

  initial begin
    logic [79:0] pass_f, add_f;

    // Power-on reset
    #2;
    chk_reset_outputs("por");
    @(posedge clk);
    #2;
    rst = 1'b0;

    // 1: push on idle ring, inserted two cycles later with src forced
    add_f = mk(1'b1, 6'd5, 6'd0, 3'd2, 64'hA5);
    step(IDLE, add_f);
    step(IDLE, IDLE);
    chk("plan1_flit", ring_out, mk(1'b1, 6'd5, 6'd1, 3'd2, 64'hA5));

    // 2: drop and insertion in the same cycle
    pass_f = mk(1'b1, 6'd7, 6'd2, 3'd0, 64'h55);
    step(pass_f, mk(1'b1, 6'd8, 6'd3, 3'd1, 64'hBEEF));
    step(mk(1'b1, 6'd1, 6'd7, 3'd0, 64'h1234), IDLE);

    // 3: foreign broadcast then own broadcast
    step(mk(1'b1, 6'h3F, 6'd4, 3'd3, 64'hCAFE), IDLE);
    step(mk(1'b1, 6'h3F, 6'd1, 3'd3, 64'hF00D), mk(1'b1, 6'd2, 6'd0, 3'd0, 64'h77));
    step(IDLE, IDLE);

    // 4: orphan removal and one-cycle error pulse
    step(mk(1'b1, 6'd9, 6'd1, 3'd0, 64'h99), IDLE);
    step(IDLE, IDLE);

    // 5: fill under PASS traffic, overflow, then drain in order
    for (int i = 0; i < 5; i++)
      step(pass_f, mk(1'b1, 6'(10 + i), 6'd0, 3'd0, 64'(i)));
    for (int i = 0; i < 6; i++) step(IDLE, IDLE);

    // 6: simultaneous push and pop while full, then async reset mid-stream
    do_reset();
    for (int i = 0; i < 4; i++)
      step(pass_f, mk(1'b1, 6'(20 + i), 6'd0, 3'd1, 64'(100 + i)));
    step(IDLE, mk(1'b1, 6'd30, 6'd0, 3'd1, 64'h200));
    step(pass_f, IDLE);
    step(IDLE, IDLE);
    #3;
    rst = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(IDLE, IDLE);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(rnd_ring(), ($urandom_range(0, 9) < 4) ?
           mk(1'b1, 6'($urandom), 6'($urandom), 3'($urandom), {$urandom, $urandom}) : IDLE);
    for (int i = 0; i < 6; i++) step(IDLE, IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
